// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single 16K video RAM bank between video fetch (always wins) and the CPU.
// Latency: CPU req->ack minimum 2 ce ticks (IDLE->ACCESS->DONE), stretched by contention windows.
// Backpressure: cpu_wait stalls the CPU while video owns the bank; request is level, held until cpu_ack.
// Optional feature macro: VRAM_ARB_STATS_EN adds stat_clr/stat_stall (ce ticks spent stalled).
module vram_arbiter #(
  parameter int AW  = 14,
  parameter int DW  = 8,
  parameter int VAW = 13
) (
  input  logic           clock,
  input  logic           nreset,
  input  logic           ce,
  input  logic           vrd,
  input  logic           vcn,
  input  logic [VAW-1:0] va,
  output logic [DW-1:0]  vd,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [AW-1:0]  cpu_a,
  input  logic [DW-1:0]  cpu_d,
  output logic [DW-1:0]  cpu_q,
  output logic           cpu_ack,
  output logic           cpu_wait,
  output logic [AW-1:0]  ram_a,
  output logic [DW-1:0]  ram_d,
  output logic           ram_we,
  input  logic [DW-1:0]  ram_q
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic           stat_clr,
  output logic [15:0]    stat_stall
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic            r_we;
  logic [DW-1:0]   r_cpu_q;
  logic            r_cpu_ack;
  logic            r_cpu_wait;
  logic [AW-1:0]   w_ram_a;
  logic            w_ram_we;

  // Video address has priority on the bank; otherwise the latched CPU address drives it.
  always_comb begin
    w_ram_a = r_addr;
    if (vrd) begin
      w_ram_a = {{(AW-VAW){1'b0}}, va};
    end
  end

  // Write strobe only while the CPU owns the slot and video is not reading.
  always_comb begin
    w_ram_we = 1'b0;
    if ((r_state == ST_ACCESS) && r_we && !vrd) begin
      w_ram_we = 1'b1;
    end
  end

  assign ram_a    = w_ram_a;
  assign ram_we   = w_ram_we;
  assign ram_d    = r_data;
  assign vd       = ram_q;
  assign cpu_q    = r_cpu_q;
  assign cpu_ack  = r_cpu_ack;
  assign cpu_wait = r_cpu_wait;

  // Arbitration FSM with registered CPU-side outputs; advances only on ce.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_cpu_q    <= '0;
      r_cpu_ack  <= 1'b0;
      r_cpu_wait <= 1'b0;
    end else if (ce) begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_addr <= cpu_a;
            r_data <= cpu_d;
            r_we   <= cpu_we;
            if (vcn || vrd) begin
              r_state    <= ST_WAIT;
              r_cpu_wait <= 1'b1;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (!vcn && !vrd) begin
            r_state    <= ST_ACCESS;
            r_cpu_wait <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // Video stole the slot mid-access: give it up and retry once the bank is free.
          if (vrd) begin
            r_state    <= ST_WAIT;
            r_cpu_wait <= 1'b1;
          end else begin
            if (!r_we) begin
              r_cpu_q <= ram_q;
            end
            r_cpu_ack <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_cpu_ack <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cpu_ack  <= 1'b0;
          r_cpu_wait <= 1'b0;
        end
      endcase
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stat_stall;

  // Count ce ticks spent stalled; clear beats increment, saturates at all-ones.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_stat_stall <= '0;
    end else if (ce) begin
      if (stat_clr) begin
        r_stat_stall <= '0;
      end else if ((r_state == ST_WAIT) && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios plus a randomized run scored against a schedule-level model.
// The model works out, from the ce/vcn/vrd sequences alone, when each CPU request must finish.
// A behavioural RAM with a backdoor stands in for the RAM macro.
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int VAW = 13;
  localparam int NC  = 900;

  logic           clock   = 1'b0;
  logic           nreset  = 1'b0;
  logic           ce      = 1'b0;
  logic           vrd     = 1'b0;
  logic           vcn     = 1'b0;
  logic [VAW-1:0] va      = '0;
  logic [DW-1:0]  vd;
  logic           cpu_req = 1'b0;
  logic           cpu_we  = 1'b0;
  logic [AW-1:0]  cpu_a   = '0;
  logic [DW-1:0]  cpu_d   = '0;
  logic [DW-1:0]  cpu_q;
  logic           cpu_ack;
  logic           cpu_wait;
  logic [AW-1:0]  ram_a;
  logic [DW-1:0]  ram_d;
  logic           ram_we;
  logic [DW-1:0]  ram_q;
`ifdef VRAM_ARB_STATS_EN
  logic           stat_clr = 1'b0;
  logic [15:0]    stat_stall;
`endif

  logic           bd_init = 1'b0;
  logic           bd_we   = 1'b0;
  logic [AW-1:0]  bd_a    = '0;
  logic [DW-1:0]  bd_d    = '0;
  logic [DW-1:0]  ram [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  // randomized-run schedule and expectations
  bit            rce  [NC];
  bit            rvcn [NC];
  bit            rvrd [NC];
  bit            rreq [NC];
  bit            rwe  [NC];
  logic [AW-1:0] ra   [NC];
  logic [DW-1:0] rd   [NC];
  bit            xack [NC];
  bit            xwait[NC];
  bit            xqv  [NC];
  logic [DW-1:0] xq   [NC];
  logic [DW-1:0] mdl  [8];

  vram_arbiter #(.AW(AW), .DW(DW), .VAW(VAW)) dut (
    .clock(clock), .nreset(nreset), .ce(ce), .vrd(vrd), .vcn(vcn), .va(va), .vd(vd),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q),
    .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we),
    .ram_q(ram_q)
`ifdef VRAM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_stall(stat_stall)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] pat(input int a);
    return 8'((a * 37) + 11);
  endfunction

  function automatic logic [AW-1:0] pool_addr(input int p);
    return 14'(32'h2000 + p * 13);
  endfunction

  // RAM macro stand-in: ce-qualified write, combinational read.
  always @(posedge clock) begin
    if (bd_init) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= pat(i);
    end else if (bd_we) begin
      ram[bd_a] <= bd_d;
    end else if (ce && ram_we) begin
      ram[ram_a] <= ram_d;
    end
  end
  assign ram_q = ram[ram_a];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int ntick(input int c);
    for (int k = c + 1; k < NC; k++) if (rce[k]) return k;
    return NC;
  endfunction

  function automatic int nfree(input int c);
    for (int k = c + 1; k < NC; k++) if (rce[k] && !rvcn[k] && !rvrd[k]) return k;
    return NC;
  endfunction

  task automatic test_reset();
    tick();
    n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
    n_cmp++; if (cpu_wait !== 1'b0) begin n_bad++; $display("FAIL reset_wait: got %b want 0", cpu_wait); end
    n_cmp++; if (cpu_q !== 8'h00) begin n_bad++; $display("FAIL reset_q: got %h want 00", cpu_q); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", ram_we); end
    n_cmp++; if (ram_a !== 14'h0000) begin n_bad++; $display("FAIL reset_ram_a: got %h want 0000", ram_a); end
    n_cmp++; if (ram_d !== 8'h00) begin n_bad++; $display("FAIL reset_ram_d: got %h want 00", ram_d); end
`ifdef VRAM_ARB_STATS_EN
    n_cmp++; if (stat_stall !== 16'h0000) begin n_bad++; $display("FAIL reset_stat: got %h want 0000", stat_stall); end
`endif
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_read_uncontended();
    int  k_ack = -1;
    bit  saw_wait = 1'b0;
    bd_a = 14'h0123; bd_d = 8'h5A; bd_we = 1'b1; ce = 1'b0;
    tick();
    bd_we = 1'b0;
    ce = 1'b1; vcn = 1'b0; vrd = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0123; cpu_d = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cpu_wait) saw_wait = 1'b1;
      if (cpu_ack) begin k_ack = i; cpu_req = 1'b0; break; end
    end
    n_cmp++; if (k_ack !== 2) begin n_bad++; $display("FAIL read_latency: got %0d ticks want 2", k_ack); end
    n_cmp++; if (cpu_q !== 8'h5A) begin n_bad++; $display("FAIL read_data: got %h want 5A", cpu_q); end
    n_cmp++; if (saw_wait !== 1'b0) begin n_bad++; $display("FAIL read_nowait: got %b want 0", saw_wait); end
    tick();
    n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL read_ack_pulse: got %b want 0", cpu_ack); end
  endtask

  task automatic test_write_contended();
    int wait_cnt = 0;
    int we_tick  = -1;
    int ack_tick = -1;
    ce = 1'b1; vrd = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h1800; cpu_d = 8'hC3;
    for (int i = 0; i < 20; i++) begin
      vcn = (i < 6);
      tick();
      if (cpu_wait) wait_cnt++;
      if (ram_we && we_tick < 0) we_tick = i;
      if (cpu_ack) begin ack_tick = i; cpu_req = 1'b0; break; end
    end
    vcn = 1'b0;
    n_cmp++; if (wait_cnt !== 6) begin n_bad++; $display("FAIL wr_wait_ticks: got %0d want 6", wait_cnt); end
    n_cmp++; if (we_tick !== 6) begin n_bad++; $display("FAIL wr_we_slot: got %0d want 6", we_tick); end
    n_cmp++; if (ack_tick !== 7) begin n_bad++; $display("FAIL wr_ack_tick: got %0d want 7", ack_tick); end
    n_cmp++; if (ram[14'h1800] !== 8'hC3) begin n_bad++; $display("FAIL wr_mem: got %h want C3", ram[14'h1800]); end
    tick();
  endtask

  task automatic test_video_priority();
    int ack_tick = -1;
    ce = 1'b1; vcn = 1'b1; vrd = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0555; cpu_d = 8'h77;
    tick();
    tick();
    vrd = 1'b1; va = 13'h0ABC;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (ram_a !== 14'h0ABC) begin n_bad++; $display("FAIL vid_ram_a: got %h want 0ABC", ram_a); end
      n_cmp++; if (vd !== pat(32'h0ABC)) begin n_bad++; $display("FAIL vid_vd: got %h want %h", vd, pat(32'h0ABC)); end
      n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL vid_we: got %b want 0", ram_we); end
      n_cmp++; if (cpu_wait !== 1'b1) begin n_bad++; $display("FAIL vid_wait: got %b want 1", cpu_wait); end
      tick();
    end
    vcn = 1'b0; vrd = 1'b0;
    tick();
    n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL vid_access_we: got %b want 1", ram_we); end
    cpu_req = 1'b0;
    vrd = 1'b1;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL overlap_we: got %b want 0", ram_we); end
    tick();
    n_cmp++; if (cpu_wait !== 1'b1) begin n_bad++; $display("FAIL overlap_retry_wait: got %b want 1", cpu_wait); end
    n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL overlap_ack: got %b want 0", cpu_ack); end
    n_cmp++; if (ram[14'h0555] !== pat(32'h0555)) begin n_bad++; $display("FAIL overlap_mem: got %h want %h", ram[14'h0555], pat(32'h0555)); end
    vrd = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cpu_ack) begin ack_tick = i; break; end
    end
    n_cmp++; if (ack_tick !== 2) begin n_bad++; $display("FAIL retry_ack_tick: got %0d want 2", ack_tick); end
    n_cmp++; if (ram[14'h0555] !== 8'h77) begin n_bad++; $display("FAIL retry_mem: got %h want 77", ram[14'h0555]); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    bit saw = 1'b0;
    ce = 1'b1; vcn = 1'b0; vrd = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0AAA; cpu_d = 8'hEE;
    tick();
    n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL rst_pre_we: got %b want 1", ram_we); end
    cpu_req = 1'b0;
    nreset = 1'b0;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", ram_we); end
    n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", cpu_ack); end
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack || cpu_wait || ram_we) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL rst_no_ack: got activity %b want 0", saw); end
    n_cmp++; if (ram[14'h0AAA] !== pat(32'h0AAA)) begin n_bad++; $display("FAIL rst_mem: got %h want %h", ram[14'h0AAA], pat(32'h0AAA)); end
  endtask

  task automatic test_back_to_back();
    int n_ack = 0;
    int t1 = -1;
    int t2 = -1;
    logic [DW-1:0] q1 = '0;
    logic [DW-1:0] q2 = '0;
    ce = 1'b1; vcn = 1'b0; vrd = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0010;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cpu_ack) begin
        n_ack++;
        if (t1 < 0) begin t1 = i; q1 = cpu_q; cpu_a = 14'h0020; end
        else if (t2 < 0) begin t2 = i; q2 = cpu_q; cpu_req = 1'b0; end
      end
    end
    n_cmp++; if (t1 !== 2) begin n_bad++; $display("FAIL b2b_first_ack: got %0d want 2", t1); end
    n_cmp++; if (t2 !== 5) begin n_bad++; $display("FAIL b2b_second_ack: got %0d want 5", t2); end
    n_cmp++; if (n_ack !== 2) begin n_bad++; $display("FAIL b2b_ack_count: got %0d want 2", n_ack); end
    n_cmp++; if (q1 !== pat(32'h0010)) begin n_bad++; $display("FAIL b2b_q1: got %h want %h", q1, pat(32'h0010)); end
    n_cmp++; if (q2 !== pat(32'h0020)) begin n_bad++; $display("FAIL b2b_q2: got %h want %h", q2, pat(32'h0020)); end
  endtask

  task automatic test_random();
    int a, t, w, k, d, p, nxt_a, last;
    bit ok, drop, wr, vs;
    logic [DW-1:0] dat;
    int wbeg[$];
    int wend[$];
    vs = 1'b0;
    for (int x = 0; x < NC; x++) begin
      rce[x] = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 5) == 0) vs = ~vs;
      rvcn[x] = vs;
      rvrd[x] = ($urandom_range(0, 4) == 0);
      rreq[x] = 1'b0;
      ra[x] = 14'($urandom); rd[x] = 8'($urandom); rwe[x] = 1'($urandom);
      xack[x] = 1'b0; xwait[x] = 1'b0; xqv[x] = 1'b0; xq[x] = '0;
    end
    for (int i = 0; i < 8; i++) mdl[i] = pat(int'(pool_addr(i)));
    // Schedule requests one after another and derive when each must complete.
    nxt_a = 3;
    while (nxt_a < NC - 4) begin
      a = nxt_a;
      t = ntick(a - 1);
      if (t >= NC) break;
      wbeg.delete(); wend.delete();
      ok = 1'b1;
      k = NC;
      if (rvcn[t] || rvrd[t]) begin
        w = nfree(t); wbeg.push_back(t + 1); wend.push_back(w);
      end else begin
        w = t;
      end
      while (ok) begin
        if (w >= NC) begin ok = 1'b0; break; end
        k = ntick(w);
        if (k >= NC) begin ok = 1'b0; break; end
        if (!rvrd[k]) break;
        w = nfree(k); wbeg.push_back(k + 1); wend.push_back(w);
      end
      if (!ok) break;
      d = ntick(k);
      if (d >= NC) break;
      p = $urandom_range(0, 7); wr = 1'($urandom); dat = 8'($urandom);
      drop = ($urandom_range(0, 3) == 0);
      for (int x = a; x <= t; x++) begin ra[x] = pool_addr(p); rd[x] = dat; rwe[x] = wr; end
      last = drop ? t : k;
      for (int x = a; x <= last; x++) rreq[x] = 1'b1;
      foreach (wbeg[i]) for (int x = wbeg[i]; x <= wend[i]; x++) xwait[x] = 1'b1;
      for (int x = k + 1; x <= d; x++) xack[x] = 1'b1;
      if (wr) mdl[p] = dat;
      else for (int x = k + 1; x < NC; x++) begin xqv[x] = 1'b1; xq[x] = mdl[p]; end
      nxt_a = d + 1 + $urandom_range(0, 3);
    end
    for (int x = 0; x < NC; x++) begin
      ce = rce[x]; vcn = rvcn[x]; vrd = rvrd[x]; va = 13'($urandom);
      cpu_req = rreq[x]; cpu_we = rwe[x]; cpu_a = ra[x]; cpu_d = rd[x];
      #1;
      n_cmp++; if (cpu_ack !== xack[x]) begin n_bad++; $display("FAIL rnd_ack cycle %0d: got %b want %b", x, cpu_ack, xack[x]); end
      n_cmp++; if (cpu_wait !== xwait[x]) begin n_bad++; $display("FAIL rnd_wait cycle %0d: got %b want %b", x, cpu_wait, xwait[x]); end
      if (xqv[x]) begin
        n_cmp++; if (cpu_q !== xq[x]) begin n_bad++; $display("FAIL rnd_q cycle %0d: got %h want %h", x, cpu_q, xq[x]); end
      end
      if (vrd) begin
        n_cmp++;
        if (ram_a !== {1'b0, va} || ram_we !== 1'b0) begin
          n_bad++; $display("FAIL rnd_video cycle %0d: got ram_a %h we %b want %h we 0", x, ram_a, ram_we, {1'b0, va});
        end
      end
      tick();
    end
    ce = 1'b1; vcn = 1'b0; vrd = 1'b0; cpu_req = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (ram[pool_addr(i)] !== mdl[i]) begin n_bad++; $display("FAIL rnd_mem addr %h: got %h want %h", pool_addr(i), ram[pool_addr(i)], mdl[i]); end
    end
  endtask

`ifdef VRAM_ARB_STATS_EN
  task automatic test_stats();
    ce = 1'b1; vcn = 1'b0; vrd = 1'b0; cpu_req = 1'b0;
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    n_cmp++; if (stat_stall !== 16'd0) begin n_bad++; $display("FAIL stat_clear: got %0d want 0", stat_stall); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0030;
    for (int i = 0; i < 30; i++) begin
      vcn = (i < 10);
      tick();
      if (cpu_ack) begin cpu_req = 1'b0; break; end
    end
    vcn = 1'b0; cpu_req = 1'b0;
    tick();
    n_cmp++; if (stat_stall !== 16'd10) begin n_bad++; $display("FAIL stat_count: got %0d want 10", stat_stall); end
    vcn = 1'b1; cpu_req = 1'b1;
    tick(); tick(); tick();
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    n_cmp++; if (stat_stall !== 16'd0) begin n_bad++; $display("FAIL stat_clr_wins: got %0d want 0", stat_stall); end
    tick();
    n_cmp++; if (stat_stall !== 16'd1) begin n_bad++; $display("FAIL stat_after_clr: got %0d want 1", stat_stall); end
    vcn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ack) begin cpu_req = 1'b0; break; end
    end
    cpu_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bd_init = 1'b1;
    tick();
    bd_init = 1'b0;
    test_reset();
    test_read_uncontended();
    test_write_contended();
    test_video_priority();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
`ifdef VRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
